uart_cmd_rx: RTL and testbench

UART_CMD_RX -- requirements
Module: uart_cmd_rx

---
 rtl/uart_cmd_rx.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver with a 4-byte command frame parser (cmd, val0, val1, CR/LF).
// Emits validated frames on chr_* with a one-cycle rx_msg_done; discarded frames pulse rx_err.
module uart_cmd_rx #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_CLKS = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] chr_cmd,
  output logic [7:0] chr_val0,
  output logic [7:0] chr_val1,
  output logic       rx_msg_done,
  output logic       rx_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF_M1      = (CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0;
  localparam int TO_W         = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_M1);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  function automatic logic is_term(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  function automatic logic is_cmd(input logic [7:0] b);
    return ((b >= 8'h41) && (b <= 8'h44)) || (b == 8'h4C);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  rx_state_t        state_r, state_s;
  logic             rx_meta_r, rx_sync_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             byte_valid_r, framing_err_r;
  logic             cnt_clr_s, shift_en_s, byte_ok_s, frm_err_s;

  logic [1:0]       idx_r, idx_s;
  logic [7:0]       cmd_hold_r, val0_hold_r, val1_hold_r;
  logic [7:0]       cmd_hold_s, val0_hold_s, val1_hold_s;
  logic [TO_W-1:0]  to_cnt_r;
  logic             to_hit_s, msg_ok_s, err_s;
  logic             msg_ok_r, err_r;

  logic [7:0]       chr_cmd_r, chr_val0_r, chr_val1_r;
  logic             rx_msg_done_r, rx_err_r;

  // Two-flop synchronizer for the asynchronous line, idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Receiver next-state and per-cycle control strobes.
  always_comb begin
    state_s    = state_r;
    cnt_clr_s  = 1'b0;
    shift_en_s = 1'b0;
    byte_ok_s  = 1'b0;
    frm_err_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_clr_s = 1'b1;
        if (!rx_sync_r) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_clr_s = 1'b1;
          // A start bit that is gone by mid-bit was a glitch: back to idle quietly.
          if (!rx_sync_r) begin
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_clr_s  = 1'b1;
          shift_en_s = 1'b1;
          if (bit_idx_r == 3'd7) begin
            state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_clr_s = 1'b1;
          state_s   = IDLE;
          if (rx_sync_r) begin
            byte_ok_s = 1'b1;
          end else begin
            frm_err_s = 1'b1;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s   = IDLE;
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // Bit timing counter, data shifter and byte strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r         <= '0;
      bit_idx_r     <= 3'd0;
      shift_r       <= 8'h00;
      byte_valid_r  <= 1'b0;
      framing_err_r <= 1'b0;
    end else begin
      cnt_r <= cnt_clr_s ? '0 : cnt_r + CNT_W'(1);
      if (state_r != DATA) begin
        bit_idx_r <= 3'd0;
      end else if (shift_en_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
      end
      if (shift_en_s) begin
        shift_r <= {rx_sync_r, shift_r[7:1]};
      end
      byte_valid_r  <= byte_ok_s;
      framing_err_r <= frm_err_s;
    end
  end

  assign to_hit_s = (idx_r != 2'd0) && (to_cnt_r == TO_MAX);

  // Frame parser: collects bytes, validates at the terminator, merges all error sources.
  always_comb begin
    idx_s       = idx_r;
    cmd_hold_s  = cmd_hold_r;
    val0_hold_s = val0_hold_r;
    val1_hold_s = val1_hold_r;
    msg_ok_s    = 1'b0;
    err_s       = 1'b0;
    if (byte_valid_r) begin
      case (idx_r)
        2'd0: begin
          if (is_term(shift_r)) begin
            idx_s = 2'd0;
          end else begin
            cmd_hold_s = shift_r;
            idx_s      = 2'd1;
          end
        end
        2'd1: begin
          if (is_term(shift_r)) begin
            err_s = 1'b1;
            idx_s = 2'd0;
          end else begin
            val0_hold_s = shift_r;
            idx_s       = 2'd2;
          end
        end
        2'd2: begin
          if (is_term(shift_r)) begin
            err_s = 1'b1;
            idx_s = 2'd0;
          end else begin
            val1_hold_s = shift_r;
            idx_s       = 2'd3;
          end
        end
        2'd3: begin
          idx_s = 2'd0;
          if (is_term(shift_r) && is_cmd(cmd_hold_r) &&
              is_digit(val0_hold_r) && is_digit(val1_hold_r)) begin
            msg_ok_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end
        default: begin
          idx_s = 2'd0;
        end
      endcase
    end else if (to_hit_s) begin
      err_s = 1'b1;
      idx_s = 2'd0;
    end else begin
      err_s = 1'b0;
    end
    if (framing_err_r) begin
      err_s = 1'b1;
      idx_s = 2'd0;
    end else begin
      msg_ok_s = msg_ok_s;
    end
  end

  // Parser state, holding registers and saturating inter-byte timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r       <= 2'd0;
      cmd_hold_r  <= 8'h00;
      val0_hold_r <= 8'h00;
      val1_hold_r <= 8'h00;
      to_cnt_r    <= '0;
      msg_ok_r    <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      idx_r       <= idx_s;
      cmd_hold_r  <= cmd_hold_s;
      val0_hold_r <= val0_hold_s;
      val1_hold_r <= val1_hold_s;
      msg_ok_r    <= msg_ok_s;
      err_r       <= err_s;
      if (byte_valid_r) begin
        to_cnt_r <= '0;
      end else if (to_cnt_r != TO_MAX) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
    end
  end

  // Output stage: chr_* move only together with rx_msg_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chr_cmd_r     <= 8'h00;
      chr_val0_r    <= 8'h00;
      chr_val1_r    <= 8'h00;
      rx_msg_done_r <= 1'b0;
      rx_err_r      <= 1'b0;
    end else begin
      rx_msg_done_r <= msg_ok_r;
      rx_err_r      <= err_r;
      if (msg_ok_r) begin
        chr_cmd_r  <= cmd_hold_r;
        chr_val0_r <= val0_hold_r;
        chr_val1_r <= val1_hold_r;
      end
    end
  end

  assign chr_cmd     = chr_cmd_r;
  assign chr_val0    = chr_val0_r;
  assign chr_val1    = chr_val1_r;
  assign rx_msg_done = rx_msg_done_r;
  assign rx_err      = rx_err_r;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: stimulus pushes expected pulses, a negedge monitor pops and checks.
module tb_uart_cmd_rx;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] chr_cmd, chr_val0, chr_val1;
  logic       rx_msg_done, rx_err;

  uart_cmd_rx #(
    .CLK_FREQ    (1_000_000),
    .BAUD        (100_000),
    .TIMEOUT_CLKS(200)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .chr_cmd    (chr_cmd),
    .chr_val0   (chr_val0),
    .chr_val1   (chr_val1),
    .rx_msg_done(rx_msg_done),
    .rx_err     (rx_err)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] c;
    logic [7:0] v0;
    logic [7:0] v1;
    int         lo;
    int         hi;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] m_cmd, m_v0, m_v1;
  logic       prev_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_cmd = 8'h00; m_v0 = 8'h00; m_v1 = 8'h00; prev_done = 1'b0;
    end else begin
      if (rx_msg_done || rx_err) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b at cyc %0d, none expected", rx_msg_done, rx_err, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (rx_err !== e.is_err || rx_msg_done !== !e.is_err) begin
            errors++;
            $display("FAIL pulse_kind: done=%0b err=%0b, expected err=%0b", rx_msg_done, rx_err, e.is_err);
          end else if (!e.is_err) begin
            if ({chr_cmd, chr_val0, chr_val1} !== {e.c, e.v0, e.v1}) begin
              errors++;
              $display("FAIL frame_data: got %h %h %h, expected %h %h %h", chr_cmd, chr_val0, chr_val1, e.c, e.v0, e.v1);
            end
            if (e.lo >= 0 && (cyc < e.lo || cyc > e.hi)) begin
              errors++;
              $display("FAIL done_latency: cyc %0d, expected %0d..%0d", cyc, e.lo, e.hi);
            end
          end
          if (!e.is_err) begin
            m_cmd = e.c; m_v0 = e.v0; m_v1 = e.v1;
          end
        end
      end else begin
        checks++;
        if ({chr_cmd, chr_val0, chr_val1} !== {m_cmd, m_v0, m_v1}) begin
          errors++;
          $display("FAIL chr_hold: got %h %h %h, expected %h %h %h", chr_cmd, chr_val0, chr_val1, m_cmd, m_v0, m_v1);
        end
      end
      if (rx_msg_done && prev_done) begin
        errors++;
        $display("FAIL done_back_to_back: done high two cycles, expected single pulse");
      end
      prev_done = rx_msg_done;
    end
  end

  task automatic bit_out(input logic v);
    rx = v;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop_bit);
    rx = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_done(input logic [7:0] c, input logic [7:0] v0, input logic [7:0] v1, input int lo, input int hi);
    exp_t e;
    e.is_err = 1'b0; e.c = c; e.v0 = v0; e.v1 = v1; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.c = 8'h00; e.v0 = 8'h00; e.v1 = 8'h00; e.lo = -1; e.hi = -1;
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    checks++;
    if ({chr_cmd, chr_val0, chr_val1, rx_msg_done, rx_err} !== {24'h000000, 2'b00}) begin
      errors++;
      $display("FAIL %s: got %h %h %h done=%0b err=%0b, expected 00 00 00 0 0", tag, chr_cmd, chr_val0, chr_val1, rx_msg_done, rx_err);
    end
  endtask

  initial begin
    int t0;
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) check_reset_outputs("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(20);

    // "A25\n": terminator starts at t0, stop-bit sampled ~98 clk later, done 2 clk after that.
    push_done(8'h41, 8'h32, 8'h35, 0, 0);
    sb.delete(0);
    send_str("A25");
    t0 = cyc;
    push_done(8'h41, 8'h32, 8'h35, t0 + 97, t0 + 103);
    send_byte(8'h0A, 1'b1);
    idle(30);

    // CR LF pair, then a second frame.
    push_done(8'h4C, 8'h31, 8'h30, -1, -1);
    push_done(8'h44, 8'h30, 8'h37, -1, -1);
    send_str("L10\r\nD07\n");
    idle(30);

    // Bad cmd, early terminator, missing terminator.
    push_err(); push_err(); push_err();
    send_str("X12\nB1\nC123");
    idle(30);

    // Inter-byte timeout, then a clean frame.
    push_err();
    send_str("C3");
    idle(250);
    push_done(8'h43, 8'h34, 8'h30, -1, -1);
    send_str("C40\n");
    idle(30);

    // Framing error mid-frame, then a short idle glitch, then recovery.
    push_err();
    send_str("A");
    send_byte(8'h39, 1'b0);
    idle(40);
    rx = 1'b0; idle(4); rx = 1'b1;
    idle(60);
    push_done(8'h41, 8'h39, 8'h39, -1, -1);
    send_str("A99\r");
    idle(30);

    // Reset in the middle of val0.
    send_str("A");
    bit_out(1'b0); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) check_reset_outputs("midframe_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(20);
    push_done(8'h42, 8'h30, 8'h35, -1, -1);
    send_str("B05\n");

    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
    idle(20);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pulses still pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
